thread_pc_gen: RTL

- Per-thread program counter generator and fetch-redirect stage, directly downstream of br_control.
- Consumes br_control's resolved branch FIFO head (pc_n, thread_id, fifo_empty) and returns pc_ack to pop it.
- Round-robins fetch PCs across hardware threads toward the instruction fetch stage.
- Applies branch redirects to the owning thread and flags a flush for that thread.

---
 rtl/thread_pc_gen.sv | 128 ++++++++++++
 1 files changed

// File: rtl/thread_pc_gen.sv
// Per-thread PC generator: round-robin fetch plus branch redirect with flush.
// Define PC_ALIGN_CHECK_EN to halt threads on misaligned targets (adds misalign_o).
module thread_pc_gen #(
  parameter int XLEN = 32,
  parameter int THREAD_WIDTH = 1,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_i,
  input  logic [XLEN-1:0]         br_pc_n_i,
  input  logic [THREAD_WIDTH-1:0] br_thread_id_i,
  input  logic                    br_fifo_empty_i,
  output logic                    br_pc_ack_o,
  output logic                    fetch_valid_o,
  output logic [XLEN-1:0]         fetch_pc_o,
  output logic [THREAD_WIDTH-1:0] fetch_thread_o,
  input  logic                    fetch_ready_i,
  output logic                    flush_o,
  output logic [THREAD_WIDTH-1:0] flush_thread_o
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic                    misalign_o
`endif
);

  localparam int TW = THREAD_WIDTH;
  localparam int NT = 2 ** THREAD_WIDTH;

  typedef enum logic {RUN, ACK} state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc [NT];
  logic [TW-1:0]   rr;
  logic [TW-1:0]   pick;
  logic            pick_ok;
  logic [NT-1:0]   halted;
  logic            redir;
  logic            bad;
  logic            hold;
  logic            withdraw;
  logic            collide;
  logic [XLEN-1:0] target;

  // FIFO head is only trusted in RUN; in ACK it is stale until after the pop
  assign redir    = (state == RUN) && !br_fifo_empty_i && !stall_i;
  assign target   = br_pc_n_i & ~XLEN'(3);
  assign hold     = fetch_valid_o && !fetch_ready_i;
  assign withdraw = hold && redir && (br_thread_id_i == fetch_thread_o);
  assign collide  = redir && (br_thread_id_i == pick);

`ifdef PC_ALIGN_CHECK_EN
  assign bad = |br_pc_n_i[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted     <= '0;
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= redir && bad;
      if (redir) halted[br_thread_id_i] <= bad;
    end
  end
`else
  assign bad    = 1'b0;
  assign halted = '0;
`endif

  // first non-halted thread at or after rr
  always_comb begin
    pick    = rr;
    pick_ok = 1'b0;
    for (int i = NT - 1; i >= 0; i--) begin
      if (!halted[rr + TW'(i)]) begin
        pick    = rr + TW'(i);
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      RUN: if (redir) state_n = ACK;
      ACK: if (!stall_i) state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NT; i++) pc[i] <= RESET_PC;
      rr             <= '0;
      br_pc_ack_o    <= 1'b0;
      fetch_valid_o  <= 1'b0;
      fetch_pc_o     <= '0;
      fetch_thread_o <= '0;
      flush_o        <= 1'b0;
      flush_thread_o <= '0;
    end else begin
      br_pc_ack_o <= (state_n == ACK);
      flush_o     <= redir;
      if (redir) flush_thread_o <= br_thread_id_i;
      if (!stall_i) begin
        if (withdraw) begin
          fetch_valid_o <= 1'b0;
        end else if (!hold) begin
          if (collide || !pick_ok) begin
            fetch_valid_o <= 1'b0;
          end else begin
            fetch_valid_o  <= 1'b1;
            fetch_pc_o     <= pc[pick];
            fetch_thread_o <= pick;
            pc[pick]       <= pc[pick] + XLEN'(4);
            rr             <= pick + TW'(1);
          end
        end
        // redirect overrides any increment of the same thread
        if (redir && !bad) pc[br_thread_id_i] <= target;
      end
    end
  end

endmodule
